logic_op_arbiter: RTL and testbench

- Shares one 32-bit logical datapath (AND/OR/XOR, selected by a 4-bit alu_ctrl) between NUM_REQ requesters.
- Arbitrates round-robin and drives the shared unit's operand/ctrl ports.
- Captures the combinational result into a single registered response slot with a valid/ready handshake.
- Sits between the issue lanes and the shared logical unit in the execute stage.

---
 rtl/logic_pkg.sv | 20 ++
 rtl/logic_op_arbiter_rr_arbiter.sv | 31 +++
 rtl/logic_op_arbiter.sv | 131 +++++++++++++
 tb/tb_logic_op_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the logical-op arbiter: op encodings, slot FSM states, ctrl width.
package logic_pkg;

    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_XOR = 4'b0100;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // True for the op codes the shared logical unit implements
    function automatic logic is_legal_op(input logic [CTRL_W-1:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_XOR);
    endfunction

endpackage

// File: rtl/logic_op_arbiter_rr_arbiter.sv
// Round-robin grant logic: first asserted request searching circularly from ptr.
// Purely combinational; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    // Circular priority search; the offset loop encodes search order, the inner loop keeps indices constant
    always_comb begin
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (en && !found && req[i] && (((32'(ptr) + off) % N) == i)) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = IDX_W'(i);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Shares one logical unit (AND/OR/XOR) between NUM_REQ requesters with a
// round-robin grant and a single registered response slot.
// Optional: define LOGIC_ARB_ILLEGAL_EN to flag unsupported alu_ctrl codes on rsp_err.
module logic_op_arbiter
    import logic_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ID_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*XLEN-1:0]   req_rs1,
    input  logic [NUM_REQ*XLEN-1:0]   req_rs2,
    input  logic [NUM_REQ*CTRL_W-1:0] req_alu_ctrl,
    output logic [XLEN-1:0]           alu_rs1,
    output logic [XLEN-1:0]           alu_rs2,
    output logic [CTRL_W-1:0]         alu_ctrl,
    input  logic [XLEN-1:0]           alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [XLEN-1:0]           rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_err
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0]    rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic               can_accept;
    logic               accept;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;

    // Slot can take a new op when empty or when its current response leaves this cycle
    assign can_accept = !rst && ((state_q == EMPTY) || rsp_ready);
    assign accept     = |gnt;
    assign req_ready  = gnt;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .en      (can_accept),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Operand mux from the granted requester; zero when nothing is granted so the unit stays quiet
    always_comb begin
        alu_rs1  = '0;
        alu_rs2  = '0;
        alu_ctrl = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                alu_rs1  = req_rs1[i*XLEN +: XLEN];
                alu_rs2  = req_rs2[i*XLEN +: XLEN];
                alu_ctrl = req_alu_ctrl[i*CTRL_W +: CTRL_W];
            end
        end
    end

    // Next-state: reload slot on accept, drain on consume, otherwise hold
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        if (accept) begin
            state_d    = FULL;
            rsp_data_d = alu_result;
            rsp_id_d   = ID_W'(gnt_idx);
            ptr_d      = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // Slot FSM, pointer and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef LOGIC_ARB_ILLEGAL_EN
    logic rsp_err_q, rsp_err_d;

    // Illegal-op flag follows the slot: captured on accept, held otherwise
    always_comb begin
        rsp_err_d = rsp_err_q;
        if (accept) begin
            rsp_err_d = !is_legal_op(alu_ctrl);
        end
    end

    // Error flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the slot and round-robin pointer.
module tb_logic_op_arbiter;

    localparam int N    = 2;
    localparam int IW   = 1;
    localparam int XLEN = 32;
    localparam int ID_W = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*XLEN-1:0]   req_rs1;
    logic [N*XLEN-1:0]   req_rs2;
    logic [N*4-1:0]      req_alu_ctrl;
    logic [XLEN-1:0]     alu_rs1;
    logic [XLEN-1:0]     alu_rs2;
    logic [3:0]          alu_ctrl;
    logic [XLEN-1:0]     alu_result;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_data;
    logic [ID_W-1:0]     rsp_id;
    logic                rsp_err;

    logic [XLEN-1:0]     rs1_a  [N];
    logic [XLEN-1:0]     rs2_a  [N];
    logic [3:0]          ctrl_a [N];

    // Model state: slot occupancy, rr pointer, held response
    bit                  m_full;
    int                  m_ptr;
    logic [XLEN-1:0]     m_data;
    int                  m_id;
    bit                  m_err;

    int                  n_cmp;
    int                  n_err;

    logic_op_arbiter #(
        .NUM_REQ (N),
        .XLEN    (XLEN),
        .ID_W    (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_alu_ctrl (req_alu_ctrl),
        .alu_rs1      (alu_rs1),
        .alu_rs2      (alu_rs2),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    // Logical unit behaviour: unsupported codes produce zero
    function automatic logic [XLEN-1:0] alu_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                input logic [3:0] c);
        case (c)
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            default: return '0;
        endcase
    endfunction

    function automatic bit illegal_ref(input logic [3:0] c);
`ifdef LOGIC_ARB_ILLEGAL_EN
        return !((c == 4'b0010) || (c == 4'b0011) || (c == 4'b0100));
`else
        return 1'b0;
`endif
    endfunction

    always_comb begin
        req_rs1      = '0;
        req_rs2      = '0;
        req_alu_ctrl = '0;
        for (int i = 0; i < N; i++) begin
            req_rs1[i*XLEN +: XLEN] = rs1_a[i];
            req_rs2[i*XLEN +: XLEN] = rs2_a[i];
            req_alu_ctrl[i*4 +: 4]  = ctrl_a[i];
        end
    end

    assign alu_result = alu_ref(alu_rs1, alu_rs2, alu_ctrl);

    // Which requester the rules say is granted this cycle, or -1
    function automatic int model_grant();
        logic [N-1:0] v;
        int idx;
        if (rst) return -1;
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            v = req_valid >> idx;
            if (v[0]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        g = model_grant();
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    // Advance one clock and apply the transaction-level effects of that edge to the model
    task automatic tick();
        int g;
        g = model_grant();
        @(posedge clk);
        if (g >= 0) begin
            m_full = 1'b1;
            m_data = alu_ref(rs1_a[IW'(g)], rs2_a[IW'(g)], ctrl_a[IW'(g)]);
            m_id   = g;
            m_err  = illegal_ref(ctrl_a[IW'(g)]);
            m_ptr  = (g + 1) % N;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_ptr  = 0;
        m_data = '0;
        m_id   = 0;
        m_err  = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            rs1_a[i]  = 32'hDEAD_BEEF;
            rs2_a[i]  = 32'h1234_5678;
            ctrl_a[i] = 4'b0011;
        end
        model_reset();
        #3;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h id=%0d e=%b required v=0 d=0 id=0 e=0",
                     rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        n_cmp++;
        if (req_ready !== '0 || alu_rs1 !== '0 || alu_rs2 !== '0 || alu_ctrl !== '0) begin
            n_err++;
            $display("FAIL reset_quiet: got rdy=%b rs1=%h rs2=%h ctrl=%h required all zero",
                     req_ready, alu_rs1, alu_rs2, alu_ctrl);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        // Fill the slot and hold it
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        tick();
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prefill: got rsp_valid=%b required 1", rsp_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
            n_err++;
            $display("FAIL reset_async: got v=%b d=%h required v=0 d=0", rsp_valid, rsp_data);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL reset_first_grant: got req_ready=%b required 01", req_ready);
        end
        req_valid = 2'b00;
        #1;
    endtask

    task automatic test_single_op();
        req_valid = 2'b01;
        rs1_a[0]  = 32'hF0F0_00FF;
        rs2_a[0]  = 32'h0FF0_FF0F;
        ctrl_a[0] = 4'b0011;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01 || alu_rs1 !== 32'hF0F0_00FF || alu_rs2 !== 32'h0FF0_FF0F || alu_ctrl !== 4'b0011) begin
            n_err++;
            $display("FAIL single_drive: got rdy=%b rs1=%h rs2=%h ctrl=%h required 01 f0f000ff 0ff0ff0f 3",
                     req_ready, alu_rs1, alu_rs2, alu_ctrl);
        end
        tick();
        req_valid = 2'b00;
        rs1_a[0]  = $urandom;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFF0_FFFF || rsp_id !== 3'd0 || rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL single_rsp: got v=%b d=%h id=%0d e=%b required 1 fff0ffff 0 0",
                     rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: got rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] prev;
        req_valid = 2'b11;
        rs1_a[0]  = $urandom;
        rs2_a[0]  = $urandom;
        ctrl_a[0] = 4'b0010;
        rs1_a[1]  = 32'hAAAA_AAAA;
        rs2_a[1]  = 32'h5555_5555;
        ctrl_a[1] = 4'b0100;
        rsp_ready = 1'b1;
        prev      = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== model_ready() || (k > 0 && req_ready === prev)) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got req_ready=%b required %b (previous %b)",
                         k, req_ready, model_ready(), prev);
            end
            prev = req_ready;
            tick();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(m_id) || rsp_data !== m_data ||
                (m_id == 1 && rsp_data !== 32'hFFFF_FFFF)) begin
                n_err++;
                $display("FAIL rr_rsp[%0d]: got v=%b id=%0d d=%h required 1 %0d %h",
                         k, rsp_valid, rsp_id, rsp_data, m_id, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] held;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        held      = m_data;
        for (int k = 0; k < 3; k++) begin
            rs1_a[0] = $urandom;
            rs1_a[1] = $urandom;
            #1;
            n_cmp++;
            if (req_ready !== '0 || rsp_valid !== 1'b1 || rsp_data !== held) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h required 00 1 %h",
                         k, req_ready, rsp_valid, rsp_data, held);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready === '0 || req_ready !== model_ready()) begin
            n_err++;
            $display("FAIL bp_release: got req_ready=%b required %b", req_ready, model_ready());
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(m_id) || rsp_data !== m_data) begin
            n_err++;
            $display("FAIL bp_reload: got v=%b id=%0d d=%h required 1 %0d %h",
                     rsp_valid, rsp_id, rsp_data, m_id, m_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]      ops [4];
        logic [XLEN-1:0] exp;
        ops[0] = 4'b0010;
        ops[1] = 4'b0011;
        ops[2] = 4'b0100;
        ops[3] = 4'b0010;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rs1_a[0]  = $urandom;
            rs2_a[0]  = $urandom;
            ctrl_a[0] = ops[k];
            case (ops[k])
                4'b0010: exp = rs1_a[0] & rs2_a[0];
                4'b0011: exp = rs1_a[0] | rs2_a[0];
                default: exp = rs1_a[0] ^ rs2_a[0];
            endcase
            #1;
            n_cmp++;
            if (req_ready !== 2'b01) begin
                n_err++;
                $display("FAIL b2b_grant[%0d]: got req_ready=%b required 01", k, req_ready);
            end
            tick();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_id !== 3'd0) begin
                n_err++;
                $display("FAIL b2b_rsp[%0d]: got v=%b d=%h id=%0d required 1 %h 0",
                         k, rsp_valid, rsp_data, rsp_id, exp);
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_illegal();
        bit exp_err;
`ifdef LOGIC_ARB_ILLEGAL_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        req_valid = 2'b10;
        rs1_a[1]  = 32'hFFFF_0000;
        rs2_a[1]  = 32'h00FF_FF00;
        ctrl_a[1] = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        tick();
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== '0 || rsp_err !== exp_err || rsp_id !== 3'd1) begin
            n_err++;
            $display("FAIL illegal_op: got v=%b d=%h e=%b id=%0d required 1 0 %b 1",
                     rsp_valid, rsp_data, rsp_err, rsp_id, exp_err);
        end
        tick();
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            rsp_ready = (($urandom % 4) != 0);
            for (int i = 0; i < N; i++) begin
                rs1_a[i] = $urandom;
                rs2_a[i] = $urandom;
                if (($urandom % 8) == 0) ctrl_a[i] = 4'($urandom);
                else                      ctrl_a[i] = 4'(2 + ($urandom % 3));
            end
            #1;
            g = model_grant();
            n_cmp++;
            if (req_ready !== model_ready()) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got %b required %b", c, req_ready, model_ready());
            end
            n_cmp++;
            if (g < 0) begin
                if (alu_rs1 !== '0 || alu_rs2 !== '0 || alu_ctrl !== '0) begin
                    n_err++;
                    $display("FAIL rand_alu_idle[%0d]: got rs1=%h rs2=%h ctrl=%h required zero",
                             c, alu_rs1, alu_rs2, alu_ctrl);
                end
            end else if (alu_rs1 !== rs1_a[IW'(g)] || alu_rs2 !== rs2_a[IW'(g)] || alu_ctrl !== ctrl_a[IW'(g)]) begin
                n_err++;
                $display("FAIL rand_alu[%0d]: got rs1=%h rs2=%h ctrl=%h required %h %h %h", c,
                         alu_rs1, alu_rs2, alu_ctrl, rs1_a[IW'(g)], rs2_a[IW'(g)], ctrl_a[IW'(g)]);
            end
            tick();
            n_cmp++;
            if (rsp_valid !== m_full ||
                (m_full && (rsp_data !== m_data || rsp_id !== ID_W'(m_id) || rsp_err !== m_err))) begin
                n_err++;
                $display("FAIL rand_rsp[%0d]: got v=%b d=%h id=%0d e=%b required %b %h %0d %b", c,
                         rsp_valid, rsp_data, rsp_id, rsp_err, m_full, m_data, m_id, m_err);
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
